// File: rtl/pc_stack_unit.sv
// Program counter with relative/absolute jumps and a return-address stack (RAS).
// Optional PC_BOUNDS_CHECK_EN adds PC_LIMIT and a sticky fault output.
module pc_stack_unit #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                INC         = 1,
    parameter int                STACK_DEPTH = 4
`ifdef PC_BOUNDS_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] PC_LIMIT    = {ADDR_W{1'b1}}
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             pc_en,
    input  logic                             jmp,
    input  logic [ADDR_W-1:0]                offset,
    input  logic                             jabs,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                target,
    input  logic                             err_clr,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp_out,
    output logic                             stk_full,
    output logic                             stk_empty,
    output logic                             ovf,
    output logic                             unf
`ifdef PC_BOUNDS_CHECK_EN
    ,
    output logic                             fault
`endif
);

    localparam int                SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int                IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]   SP_MAX = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] INC_V  = ADDR_W'(INC);

    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, pc_rel, ras_top;
    logic [SP_W-1:0]   sp, sp_nxt, sp_inc, sp_dec;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              push, redirect, ovf_set, unf_set;
    logic [ADDR_W-1:0] ras [STACK_DEPTH];

    assign pc_inc   = pc + INC_V;
    assign pc_rel   = pc + offset;
    assign sp_inc   = sp + SP_W'(1);
    assign sp_dec   = sp - SP_W'(1);
    assign push_idx = sp[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];
    assign ras_top  = ras[pop_idx];

`ifdef PC_BOUNDS_CHECK_EN
    logic              fault_set;
    logic [ADDR_W:0]   inc_wide;
    logic              inc_over;

    // Carry-extended so an increment that wraps past 2^ADDR_W also counts as crossing.
    assign inc_wide = {1'b0, pc} + {1'b0, INC_V};
    assign inc_over = inc_wide > {1'b0, PC_LIMIT};
`endif

    // One operation per cycle, chosen strictly by priority; stall freezes everything.
    always_comb begin
        pc_nxt   = pc;
        sp_nxt   = sp;
        push     = 1'b0;
        redirect = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
        fault_set = 1'b0;
`endif
        if (!stall) begin
            if (ret) begin
                if (sp != '0) begin
                    pc_nxt   = ras_top;
                    sp_nxt   = sp_dec;
                    redirect = 1'b1;
                end else begin
                    unf_set = 1'b1;
                end
            end else if (call) begin
                pc_nxt   = target;
                redirect = 1'b1;
                if (sp == SP_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    push   = 1'b1;
                    sp_nxt = sp_inc;
                end
            end else if (jabs) begin
                pc_nxt   = target;
                redirect = 1'b1;
            end else if (jmp) begin
                pc_nxt   = pc_rel;
                redirect = 1'b1;
            end else if (pc_en) begin
                pc_nxt = pc_inc;
            end
`ifdef PC_BOUNDS_CHECK_EN
            if (redirect && (pc_nxt > PC_LIMIT)) begin
                pc_nxt    = pc;
                sp_nxt    = sp;
                push      = 1'b0;
                ovf_set   = 1'b0;
                fault_set = 1'b1;
            end else if (!redirect && !ret && pc_en && inc_over) begin
                pc_nxt = RESET_VEC;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= RESET_VEC;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            fault <= 1'b0;
`endif
        end else if (!stall) begin
            pc  <= pc_nxt;
            sp  <= sp_nxt;
            // A set event in the same cycle as err_clr leaves the flag set.
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
`ifdef PC_BOUNDS_CHECK_EN
            fault <= fault_set | (fault & ~err_clr);
`endif
        end
    end

    // Stack contents need no reset: only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            ras[push_idx] <= pc_inc;
        end
    end

    assign pc_out    = pc;
    assign sp_out    = sp;
    assign stk_full  = (sp == SP_MAX);
    assign stk_empty = (sp == '0);

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (default parameters): vector table plus
// hand-written sequences for asynchronous reset.
module tb_pc_stack_unit;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall, pc_en, jmp, jabs, call, ret, err_clr;
    logic [ADDR_W-1:0] offset, target;
    logic [ADDR_W-1:0] pc_out;
    logic [2:0]        sp_out;
    logic              stk_full, stk_empty, ovf, unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall, pc_en, jmp, jabs, call, ret, err_clr;
        logic [15:0] offset, target;
        logic [15:0] e_pc;
        logic [2:0]  e_sp;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    pc_stack_unit #(
        .ADDR_W(ADDR_W), .RESET_VEC(16'h0000), .INC(1), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_en(pc_en), .jmp(jmp),
        .offset(offset), .jabs(jabs), .call(call), .ret(ret), .target(target),
        .err_clr(err_clr), .pc_out(pc_out), .sp_out(sp_out), .stk_full(stk_full),
        .stk_empty(stk_empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] e_pc, input logic [2:0] e_sp,
                               input logic e_ovf, input logic e_unf);
        check({tag, ".pc"},    32'(pc_out),    32'(e_pc));
        check({tag, ".sp"},    32'(sp_out),    32'(e_sp));
        check({tag, ".full"},  32'(stk_full),  32'(e_sp == 3'(DEPTH)));
        check({tag, ".empty"}, 32'(stk_empty), 32'(e_sp == 3'd0));
        check({tag, ".ovf"},   32'(ovf),       32'(e_ovf));
        check({tag, ".unf"},   32'(unf),       32'(e_unf));
    endtask

    task automatic idle_inputs();
        stall = 0; pc_en = 0; jmp = 0; jabs = 0; call = 0; ret = 0; err_clr = 0;
        offset = '0; target = '0;
    endtask

    // Drive one cycle of inputs at the falling edge; sample 1ns after the rising edge.
    task automatic step(input logic st, pe, jm, ja, ca, re, ec, input logic [15:0] off, tgt);
        @(negedge clk);
        stall = st; pc_en = pe; jmp = jm; jabs = ja; call = ca; ret = re; err_clr = ec;
        offset = off; target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, pe, jm, ja, ca, re, ec, input logic [15:0] off, tgt,
                       input logic [15:0] e_pc, input logic [2:0] e_sp, input logic e_ovf, e_unf);
        vec_t v;
        v.stall = st; v.pc_en = pe; v.jmp = jm; v.jabs = ja; v.call = ca; v.ret = re;
        v.err_clr = ec; v.offset = off; v.target = tgt;
        v.e_pc = e_pc; v.e_sp = e_sp; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endtask

    initial begin
        //   st pe jm ja ca re ec  offset    target     pc        sp ovf unf
        add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 16'h0005, 16'h0000, 16'h0008, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 16'hFFFE, 16'h0000, 16'h0006, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0100, 16'h0100, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0007, 0, 0, 0);
        // five nested calls into a depth-4 stack
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0200, 16'h0200, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0300, 16'h0300, 2, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0400, 16'h0400, 3, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0500, 16'h0500, 4, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0600, 16'h0600, 4, 1, 0);
        // five returns: four pops in LIFO order, then underflow with pc held
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0401, 3, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0301, 2, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0201, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0008, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0008, 0, 0, 0);
        // priority: ret beats call and pc_en
        add(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0020, 16'h0020, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 16'h0000, 16'h0777, 16'h0009, 0, 0, 0);
        // stall freezes jmp, and ignores err_clr
        add(1, 0, 1, 0, 0, 0, 0, 16'h0005, 16'h0000, 16'h0009, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0009, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0009, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0009, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0009, 0, 0, 0);
        // wrap-around arithmetic
        add(0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0002, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 16'hFFFD, 16'h0000, 16'hFFFF, 0, 0, 0);
        // jabs beats jmp and pc_en; jmp beats pc_en
        add(0, 1, 1, 1, 0, 0, 0, 16'h0001, 16'h0040, 16'h0040, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0050, 0, 0, 0);

        idle_inputs();
        reset = 1'b0;
        #20;
        check_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].pc_en, vecs[i].jmp, vecs[i].jabs, vecs[i].call,
                 vecs[i].ret, vecs[i].err_clr, vecs[i].offset, vecs[i].target);
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_sp,
                        vecs[i].e_ovf, vecs[i].e_unf);
        end

        // pc=0x0050 sp=0: set unf, push twice, then reset mid-cycle
        step(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        step(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0100);
        step(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0200);
        check_state("pre_async", 16'h0200, 3'd2, 1'b0, 1'b1);
        idle_inputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_state("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0030);
        check_state("post_reset_call", 16'h0030, 3'd1, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        check_state("post_reset_ret", 16'h0001, 3'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
